// File: rtl/red_pitaya_hk_gpio.sv
// Housekeeping block: board ID, device DNA readout, expansion GPIO with edge
// events and interrupt, and LED drive with per-LED blink.
module red_pitaya_hk_gpio #(
  parameter int unsigned DWE      = 8,
  parameter int unsigned DWL      = 8,
  parameter logic [56:0] DNA      = 57'h0823456789ABCDE,
  parameter logic [3:0]  BOARD_ID = 4'h1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            digital_loop,
  input  logic [DWE-1:0]  exp_p_dat_i,
  input  logic [DWE-1:0]  exp_n_dat_i,
  output logic [DWE-1:0]  exp_p_dat_o,
  output logic [DWE-1:0]  exp_n_dat_o,
  output logic [DWE-1:0]  exp_p_dir_o,
  output logic [DWE-1:0]  exp_n_dir_o,
  output logic [DWL-1:0]  led_o,
  output logic            irq_o,
  input  logic [31:0]     sys_addr,
  input  logic [31:0]     sys_wdata,
  input  logic            sys_wen,
  input  logic            sys_ren,
  output logic [31:0]     sys_rdata,
  output logic            sys_err,
  output logic            sys_ack
);

  localparam logic [19:0] A_ID     = 20'h00;
  localparam logic [19:0] A_DNA0   = 20'h04;
  localparam logic [19:0] A_DNA1   = 20'h08;
  localparam logic [19:0] A_LOOP   = 20'h0C;
  localparam logic [19:0] A_PDIR   = 20'h10;
  localparam logic [19:0] A_NDIR   = 20'h14;
  localparam logic [19:0] A_POUT   = 20'h18;
  localparam logic [19:0] A_NOUT   = 20'h1C;
  localparam logic [19:0] A_PIN    = 20'h20;
  localparam logic [19:0] A_NIN    = 20'h24;
  localparam logic [19:0] A_RISE   = 20'h28;
  localparam logic [19:0] A_FALL   = 20'h2C;
  localparam logic [19:0] A_EVT    = 20'h30;
  localparam logic [19:0] A_IRQEN  = 20'h34;
  localparam logic [19:0] A_LED    = 20'h38;
  localparam logic [19:0] A_BLINK  = 20'h3C;
  localparam logic [19:0] A_PERIOD = 20'h40;

  logic            r_digital_loop;
  logic [DWE-1:0]  r_p_dir, r_n_dir, r_p_out, r_n_out;
  logic [DWE-1:0]  r_p_s1, r_p_s2, r_p_s3, r_n_s1, r_n_s2, r_n_s3;
  logic [DWE-1:0]  r_p_rise_en, r_n_rise_en, r_p_fall_en, r_n_fall_en;
  logic [DWE-1:0]  r_p_irq_en, r_n_irq_en;
  logic [DWE-1:0]  r_p_hit, r_n_hit, r_p_evt, r_n_evt;
  logic            r_irq;
  logic [DWL-1:0]  r_led, r_blink_en, r_led_o;
  logic [31:0]     r_blink_period, r_blink_cnt;
  logic            r_blink_phase;
  logic            r_ack, r_err;
  logic [31:0]     r_rdata;
  logic [8:0]      r_dna_cnt;
  logic [56:0]     r_dna_value, r_dna_sr;
  logic            r_dna_done, r_dna_clk_q;

  logic [19:0]     w_addr;
  logic            w_hit, w_rw, w_err, w_wr_ok;
  logic [31:0]     w_rd;
  logic [DWE-1:0]  w_p_clr, w_n_clr;
  logic [DWL-1:0]  w_led_nxt, w_blink_en_nxt, w_led_o_nxt;
  logic            w_phase_nxt;
  logic            w_dna_clk, w_dna_read, w_dna_shift, w_dna_dout, w_dna_edge;

  function automatic logic [31:0] f_evt(input logic [DWE-1:0] p, input logic [DWE-1:0] n);
    f_evt = '0;
    f_evt[DWE-1:0]   = p;
    f_evt[DWE+15:16] = n;
  endfunction

  assign w_addr = sys_addr[19:0];

  always_comb begin
    w_hit = 1'b1;
    w_rw  = 1'b1;
    w_rd  = '0;
    case (w_addr)
      A_ID:     begin w_rw = 1'b0; w_rd = {28'h0, BOARD_ID}; end
      A_DNA0:   begin w_rw = 1'b0; w_rd = r_dna_value[31:0]; end
      A_DNA1:   begin w_rw = 1'b0; w_rd = {r_dna_done, 6'h0, r_dna_value[56:32]}; end
      A_LOOP:   w_rd = {31'h0, r_digital_loop};
      A_PDIR:   w_rd = 32'(r_p_dir);
      A_NDIR:   w_rd = 32'(r_n_dir);
      A_POUT:   w_rd = 32'(r_p_out);
      A_NOUT:   w_rd = 32'(r_n_out);
      A_PIN:    begin w_rw = 1'b0; w_rd = 32'(r_p_s2); end
      A_NIN:    begin w_rw = 1'b0; w_rd = 32'(r_n_s2); end
      A_RISE:   w_rd = f_evt(r_p_rise_en, r_n_rise_en);
      A_FALL:   w_rd = f_evt(r_p_fall_en, r_n_fall_en);
      A_EVT:    w_rd = f_evt(r_p_evt, r_n_evt);
      A_IRQEN:  w_rd = f_evt(r_p_irq_en, r_n_irq_en);
      A_LED:    w_rd = 32'(r_led);
      A_BLINK:  w_rd = 32'(r_blink_en);
      A_PERIOD: w_rd = r_blink_period;
      default:  begin w_hit = 1'b0; w_rw = 1'b0; end
    endcase
  end

  assign w_err   = ~w_hit | (sys_wen & ~w_rw);
  assign w_wr_ok = sys_wen & w_hit & w_rw;

  // Bus response: one-cycle registered ack; write cycles and errors return zero data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= sys_wen | sys_ren;
      r_err   <= (sys_wen | sys_ren) & w_err;
      r_rdata <= (sys_ren & ~sys_wen & ~w_err) ? w_rd : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_digital_loop <= 1'b0;
      r_p_dir        <= '0;
      r_n_dir        <= '0;
      r_p_out        <= '0;
      r_n_out        <= '0;
      r_p_rise_en    <= '0;
      r_n_rise_en    <= '0;
      r_p_fall_en    <= '0;
      r_n_fall_en    <= '0;
      r_p_irq_en     <= '0;
      r_n_irq_en     <= '0;
      r_led          <= '0;
      r_blink_en     <= '0;
      r_blink_period <= '0;
    end else if (w_wr_ok) begin
      case (w_addr)
        A_LOOP:   r_digital_loop <= sys_wdata[0];
        A_PDIR:   r_p_dir        <= sys_wdata[DWE-1:0];
        A_NDIR:   r_n_dir        <= sys_wdata[DWE-1:0];
        A_POUT:   r_p_out        <= sys_wdata[DWE-1:0];
        A_NOUT:   r_n_out        <= sys_wdata[DWE-1:0];
        A_RISE:   begin r_p_rise_en <= sys_wdata[DWE-1:0]; r_n_rise_en <= sys_wdata[DWE+15:16]; end
        A_FALL:   begin r_p_fall_en <= sys_wdata[DWE-1:0]; r_n_fall_en <= sys_wdata[DWE+15:16]; end
        A_IRQEN:  begin r_p_irq_en  <= sys_wdata[DWE-1:0]; r_n_irq_en  <= sys_wdata[DWE+15:16]; end
        A_LED:    r_led          <= sys_wdata[DWL-1:0];
        A_BLINK:  r_blink_en     <= sys_wdata[DWL-1:0];
        A_PERIOD: r_blink_period <= sys_wdata;
        default:  ;
      endcase
    end
  end

  // Three-stage input pipe; the edge pulse is registered once more before it sets status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_p_s1  <= '0; r_p_s2 <= '0; r_p_s3 <= '0;
      r_n_s1  <= '0; r_n_s2 <= '0; r_n_s3 <= '0;
      r_p_hit <= '0;
      r_n_hit <= '0;
    end else begin
      r_p_s1  <= exp_p_dat_i;
      r_p_s2  <= r_p_s1;
      r_p_s3  <= r_p_s2;
      r_n_s1  <= exp_n_dat_i;
      r_n_s2  <= r_n_s1;
      r_n_s3  <= r_n_s2;
      r_p_hit <= (r_p_s2 & ~r_p_s3 & r_p_rise_en) | (~r_p_s2 & r_p_s3 & r_p_fall_en);
      r_n_hit <= (r_n_s2 & ~r_n_s3 & r_n_rise_en) | (~r_n_s2 & r_n_s3 & r_n_fall_en);
    end
  end

  assign w_p_clr = (w_wr_ok && w_addr == A_EVT) ? sys_wdata[DWE-1:0]   : '0;
  assign w_n_clr = (w_wr_ok && w_addr == A_EVT) ? sys_wdata[DWE+15:16] : '0;

  // A new event on the same bit as a clear wins over the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_p_evt <= '0;
      r_n_evt <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_p_evt <= r_p_hit | (r_p_evt & ~w_p_clr);
      r_n_evt <= r_n_hit | (r_n_evt & ~w_n_clr);
      r_irq   <= |{r_p_evt & r_p_irq_en, r_n_evt & r_n_irq_en};
    end
  end

  assign w_phase_nxt    = (w_wr_ok && w_addr == A_PERIOD) ? 1'b0 :
                          (r_blink_cnt >= r_blink_period) ? ~r_blink_phase : r_blink_phase;
  assign w_led_nxt      = (w_wr_ok && w_addr == A_LED)   ? sys_wdata[DWL-1:0] : r_led;
  assign w_blink_en_nxt = (w_wr_ok && w_addr == A_BLINK) ? sys_wdata[DWL-1:0] : r_blink_en;

  // LED output is built from next-state values so a register write shows up one cycle later.
  genvar gi;
  generate
    for (gi = 0; gi < DWL; gi++) begin : g_led
      assign w_led_o_nxt[gi] = w_blink_en_nxt[gi] ? (w_led_nxt[gi] & w_phase_nxt) : w_led_nxt[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_led_o       <= '0;
    end else begin
      if (w_wr_ok && w_addr == A_PERIOD)
        r_blink_cnt <= '0;
      else if (r_blink_cnt >= r_blink_period)
        r_blink_cnt <= '0;
      else
        r_blink_cnt <= r_blink_cnt + 32'd1;
      r_blink_phase <= w_phase_nxt;
      r_led_o       <= w_led_o_nxt;
    end
  end

  assign w_dna_clk   = r_dna_cnt[2];
  assign w_dna_read  = (r_dna_cnt < 9'd10);
  assign w_dna_shift = (r_dna_cnt > 9'd18);
  assign w_dna_edge  = w_dna_clk & ~r_dna_clk_q;
  assign w_dna_dout  = r_dna_sr[56];

  // r_dna_sr behaves like the device DNA port: load on READ, shift MSB-first on SHIFT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dna_cnt   <= '0;
      r_dna_value <= '0;
      r_dna_done  <= 1'b0;
      r_dna_sr    <= '0;
      r_dna_clk_q <= 1'b0;
    end else begin
      r_dna_clk_q <= w_dna_clk;
      if (!r_dna_done)
        r_dna_cnt <= r_dna_cnt + 9'd1;
      if (w_dna_edge && !r_dna_done) begin
        if (w_dna_read)
          r_dna_sr <= DNA;
        else if (w_dna_shift)
          r_dna_sr <= {r_dna_sr[55:0], 1'b0};
      end
      if (r_dna_cnt[2:0] == 3'd0 && !r_dna_done)
        r_dna_value <= {r_dna_value[55:0], w_dna_dout};
      if (r_dna_cnt > 9'd465)
        r_dna_done <= 1'b1;
    end
  end

  assign digital_loop = r_digital_loop;
  assign exp_p_dir_o  = r_p_dir;
  assign exp_n_dir_o  = r_n_dir;
  assign exp_p_dat_o  = r_p_out;
  assign exp_n_dat_o  = r_n_out;
  assign led_o        = r_led_o;
  assign irq_o        = r_irq;
  assign sys_ack      = r_ack;
  assign sys_err      = r_err;
  assign sys_rdata    = r_rdata;

endmodule
